// File: rtl/staircase_seq_ctrl.sv
// -----------------------------------------------------------------------------
// staircase_seq_ctrl
//
// Sequencing controller for the staircase counter datapath. A start command
// carries a row limit L and a pass count P; the block then streams the values
// 1; 1,2; 1,2,3; ... 1..L, and repeats that whole pattern P times. Each value
// is one beat on a valid/ready stream, so the consumer may stall it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      command strobe, only looked at while idle
//   limit      row limit L (W bits), latched when a start is accepted
//   passes     pass count P (PW bits), latched when a start is accepted
//   abort      terminate the current run, only looked at while running
//   out_ready  consumer ready
//   out_valid  beat valid
//   out_data   current staircase value (column)
//   out_last   beat closes its row
//   out_eop    beat closes its pass
//   busy       high while running
//   done       one-cycle pulse once all passes have been delivered
//   err        one-cycle pulse after a rejected start (L==0 or P==0)
//   pass_cnt   passes completed in the current or most recent run
//
// Every output is decoded from registered state only, so no input reaches an
// output without passing through a flop.
// -----------------------------------------------------------------------------
module staircase_seq_ctrl #(
    parameter int W  = 3,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  limit,
    input  logic [PW-1:0] passes,
    input  logic          abort,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic          out_eop,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [PW-1:0] pass_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [W-1:0]  row, row_n;
    logic [W-1:0]  col, col_n;
    logic [W-1:0]  lim, lim_n;
    logic [PW-1:0] npass, npass_n;
    logic [PW-1:0] pcnt, pcnt_n;
    logic          err_q, err_n;
    logic          run;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            row   <= '0;
            col   <= '0;
            lim   <= '0;
            npass <= '0;
            pcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            row   <= row_n;
            col   <= col_n;
            lim   <= lim_n;
            npass <= npass_n;
            pcnt  <= pcnt_n;
            err_q <= err_n;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        lim_n   = lim;
        npass_n = npass;
        pcnt_n  = pcnt;
        err_n   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (limit == '0 || passes == '0) begin
                        err_n = 1'b1;
                    end else begin
                        lim_n   = limit;
                        npass_n = passes;
                        row_n   = W'(1);
                        col_n   = W'(1);
                        pcnt_n  = '0;
                        state_n = S_RUN;
                    end
                end
            end

            S_RUN: begin
                // abort wins over any same-cycle transfer: nothing advances
                if (abort) begin
                    state_n = S_IDLE;
                end else if (out_ready) begin
                    if (col != row) begin
                        col_n = col + W'(1);
                    end else if (row != lim) begin
                        row_n = row + W'(1);
                        col_n = W'(1);
                    end else begin
                        pcnt_n = pcnt + PW'(1);
                        if (pcnt_n == npass) begin
                            state_n = S_DONE;
                        end else begin
                            // next pass starts on the following cycle, no gap
                            row_n = W'(1);
                            col_n = W'(1);
                        end
                    end
                end
            end

            S_DONE: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Output decode from registered state
    assign run       = (state == S_RUN);
    assign out_valid = run;
    assign out_data  = col;
    // gated with run so that the all-zero reset state does not read as col==row
    assign out_last  = run && (col == row);
    assign out_eop   = run && (col == row) && (row == lim);
    assign busy      = run;
    assign done      = (state == S_DONE);
    assign err       = err_q;
    assign pass_cnt  = pcnt;

endmodule

// File: tb/tb_staircase_seq_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for staircase_seq_ctrl. A stimulus process issues commands and
// pushes the expected beat stream (built from nested pass/row/column loops)
// into a queue; a monitor process pops and compares on every accepted beat and
// watches that stalled beats hold steady.
// -----------------------------------------------------------------------------
module tb_staircase_seq_ctrl;

    localparam int W  = 3;
    localparam int PW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  limit;
    logic [PW-1:0] passes;
    logic          abort;
    logic          out_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          out_eop;
    logic          busy;
    logic          done;
    logic          err;
    logic [PW-1:0] pass_cnt;

    staircase_seq_ctrl #(.W(W), .PW(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .limit     (limit),
        .passes    (passes),
        .abort     (abort),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_eop   (out_eop),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pass_cnt  (pass_cnt)
    );

    typedef struct {
        int data;
        int last;
        int eop;
    } beat_t;

    beat_t q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    xfer_cnt = 0;
    bit    stall    = 1'b0;
    beat_t held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: P passes, each row r = 1..L carrying columns 1..r
    task automatic push_run(input int L, input int P);
        beat_t b;
        for (int p = 0; p < P; p++)
            for (int r = 1; r <= L; r++)
                for (int c = 1; c <= r; c++) begin
                    b.data = c;
                    b.last = (c == r) ? 1 : 0;
                    b.eop  = (c == r && r == L) ? 1 : 0;
                    q.push_back(b);
                end
    endtask

    task automatic do_start(input int L, input int P);
        limit    = L[W-1:0];
        passes   = P[PW-1:0];
        start    = 1'b1;
        xfer_cnt = 0;
        step();
        start    = 1'b0;
    endtask

    // Full run to completion. mid>0 checks the pass boundary after beat mid.
    task automatic run(input int L, input int P, input bit rnd, input int mid);
        int  cyc;
        bit  did;
        did = 1'b0;
        push_run(L, P);
        out_ready = rnd ? 1'($urandom % 2) : 1'b1;
        do_start(L, P);
        cyc = 1;
        while (!done && cyc < 3000) begin
            if (rnd) out_ready = 1'($urandom % 2);
            step();
            cyc++;
            if (mid > 0 && !did && xfer_cnt == mid) begin
                did = 1'b1;
                chk("pass_cnt_after_pass1", int'(pass_cnt), 1);
                chk("data_first_of_pass2", int'(out_data), 1);
            end
        end
        chk("done_seen", int'(done), 1);
        if (!rnd) chk("done_latency", cyc, P * L * (L + 1) / 2 + 1);
        chk("queue_drained", q.size(), 0);
        chk("pass_cnt_end", int'(pass_cnt), P);
        chk("busy_at_done", int'(busy), 0);
        chk("valid_at_done", int'(out_valid), 0);
        step();
        chk("done_one_cycle", int'(done), 0);
        out_ready = 1'b1;
    endtask

    // Monitor: compare accepted beats, check stalled beats stay put
    always @(negedge clk) begin
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (stall && out_valid) begin
                chk("stall_data_stable", int'(out_data), held.data);
                chk("stall_last_stable", int'(out_last), held.last);
                chk("stall_eop_stable",  int'(out_eop),  held.eop);
            end
            if (out_valid && out_ready) begin
                chk("beat_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    beat_t e;
                    e = q.pop_front();
                    chk("beat_data", int'(out_data), e.data);
                    chk("beat_last", int'(out_last), e.last);
                    chk("beat_eop",  int'(out_eop),  e.eop);
                end
                xfer_cnt++;
                stall = 1'b0;
            end else if (out_valid) begin
                stall     = 1'b1;
                held.data = int'(out_data);
                held.last = int'(out_last);
                held.eop  = int'(out_eop);
            end else begin
                stall = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        limit     = '0;
        passes    = '0;
        out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_valid",    int'(out_valid), 0);
        chk("rst_data",     int'(out_data),  0);
        chk("rst_last",     int'(out_last),  0);
        chk("rst_eop",      int'(out_eop),   0);
        chk("rst_busy",     int'(busy),      0);
        chk("rst_done",     int'(done),      0);
        chk("rst_err",      int'(err),       0);
        chk("rst_pass_cnt", int'(pass_cnt),  0);
        #9 rst = 1'b0;

        // Single pass, L=3; start lands on the first edge after reset release
        run(3, 1, 1'b0, 0);

        // Two passes, L=7, no gaps across row and pass boundaries
        run(7, 2, 1'b0, 28);

        // Boundaries: L=1 (every beat ends row and pass), full pass counter
        run(1, 2, 1'b0, 0);
        run(1, 255, 1'b0, 0);

        // Backpressure
        run(4, 1, 1'b1, 0);

        // Rejected commands
        out_ready = 1'b1;
        limit = '0; passes = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        chk("rej_lim_err",   int'(err),       1);
        chk("rej_lim_valid", int'(out_valid), 0);
        chk("rej_lim_busy",  int'(busy),      0);
        step();
        chk("rej_lim_err_clear", int'(err),   0);
        limit = 3'd5; passes = '0; start = 1'b1;
        step();
        start = 1'b0;
        chk("rej_pass_err",   int'(err),       1);
        chk("rej_pass_valid", int'(out_valid), 0);
        chk("rej_pass_busy",  int'(busy),      0);
        step();
        chk("rej_pass_err_clear", int'(err),   0);
        chk("rej_pass_valid2", int'(out_valid), 0);

        // Abort while showing data=2 of row 3 (beat 5) with out_ready high
        push_run(5, 1);
        out_ready = 1'b1;
        do_start(5, 1);
        n = 0;
        while (xfer_cnt != 4 && n < 50) begin
            step();
            n++;
        end
        chk("abort_reached_beat5", xfer_cnt, 4);
        chk("abort_point_data", int'(out_data), 2);
        chk("abort_point_last", int'(out_last), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        q.delete();
        chk("abort_valid",    int'(out_valid), 0);
        chk("abort_busy",     int'(busy),      0);
        chk("abort_no_done",  int'(done),      0);
        chk("abort_pass_cnt", int'(pass_cnt),  0);
        run(2, 1, 1'b0, 0);

        // Reset in the middle of a run
        push_run(3, 1);
        do_start(3, 1);
        n = 0;
        while (out_data != 3'd2 && n < 50) begin
            step();
            n++;
        end
        chk("midrst_reached_data2", int'(out_data), 2);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid",    int'(out_valid), 0);
        chk("midrst_data",     int'(out_data),  0);
        chk("midrst_last",     int'(out_last),  0);
        chk("midrst_eop",      int'(out_eop),   0);
        chk("midrst_busy",     int'(busy),      0);
        chk("midrst_done",     int'(done),      0);
        chk("midrst_err",      int'(err),       0);
        chk("midrst_pass_cnt", int'(pass_cnt),  0);
        q.delete();
        #4 rst = 1'b0;
        run(3, 2, 1'b0, 6);

        // Randomised runs with random backpressure
        for (int i = 0; i < 6; i++) begin
            run(int'($urandom_range(1, 7)), int'($urandom_range(1, 3)), 1'b1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
